// File: rtl/csr_trap_unit.sv
// M-mode trap sequencer: takes exceptions, mret and interrupts, owns the machine CSRs,
// then flushes the pipeline and redirects fetch. Optional vectored mode: CSR_TRAP_VECTORED_EN.
module csr_trap_unit #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  output logic            exc_ready_o,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_valid_i,
  input  logic            irq_take_en_i,
  input  logic [XLEN-1:0] irq_pc_i,
  input  logic            m_ext_irq_i,
  input  logic            m_sw_irq_i,
  input  logic            m_timer_irq_i,
  input  logic            csr_valid_i,
  output logic            csr_ready_o,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      priv_o
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_JUMP} state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [1:0]  PRIV_M    = 2'b11;
  localparam logic [XLEN-1:0] LOW2_CLR = ~XLEN'(3);

  state_t state_q, state_d;
  logic [1:0]      priv_q, mpp_q;
  logic            mstatus_mie_q, mpie_q;
  logic [2:0]      mie_q, mip_q;   // bit order {external, software, timer}
  logic [XLEN-3:0] mtvec_base_q;
  logic [1:0]      mtvec_mode_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, redirect_pc_q;

  logic idle, exc_take, mret_take, irq_take, csr_mapped, csr_wr;
  logic [2:0]      irq_pend;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] trap_base, irq_target;

  assign idle      = (state_q == S_IDLE);
  assign exc_take  = idle && exc_valid_i;
  assign mret_take = idle && mret_valid_i && !exc_valid_i;
  assign irq_pend  = mip_q & mie_q;
  assign irq_take  = idle && irq_take_en_i && !exc_valid_i && !mret_valid_i &&
                     ((priv_q != PRIV_M) || mstatus_mie_q) && (irq_pend != 3'b000);
  assign irq_code  = irq_pend[2] ? 4'd11 : (irq_pend[1] ? 4'd3 : 4'd7);
  assign trap_base = {mtvec_base_q, 2'b00};
  assign irq_target = (mtvec_mode_q == 2'b01) ?
                      trap_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00} : trap_base;

  // A taken interrupt outranks a CSR access in the same cycle.
  assign csr_ready_o = idle && !exc_valid_i && !mret_valid_i && !irq_take;
  assign csr_wr = csr_valid_i && csr_ready_o && csr_we_i && csr_mapped && (csr_addr_i != A_MIP);
  assign csr_illegal_o = csr_valid_i && (!csr_mapped || (csr_we_i && (csr_addr_i == A_MIP)));
  assign priv_o = priv_q;
  assign redirect_pc_o = redirect_pc_q;

  always_comb begin
    csr_rdata_o = '0;
    csr_mapped  = 1'b1;
    case (csr_addr_i)
      A_MSTATUS: begin
        csr_rdata_o[3]     = mstatus_mie_q;
        csr_rdata_o[7]     = mpie_q;
        csr_rdata_o[12:11] = mpp_q;
      end
      A_MIE: begin
        csr_rdata_o[11] = mie_q[2];
        csr_rdata_o[3]  = mie_q[1];
        csr_rdata_o[7]  = mie_q[0];
      end
      A_MIP: begin
        csr_rdata_o[11] = mip_q[2];
        csr_rdata_o[3]  = mip_q[1];
        csr_rdata_o[7]  = mip_q[0];
      end
      A_MTVEC:  csr_rdata_o = {mtvec_base_q, mtvec_mode_q};
      A_MEPC:   csr_rdata_o = mepc_q;
      A_MCAUSE: csr_rdata_o = mcause_q;
      A_MTVAL:  csr_rdata_o = mtval_q;
      default:  csr_mapped  = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    exc_ready_o      = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        exc_ready_o = 1'b1;
        if (exc_take || mret_take || irq_take) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        state_d = S_JUMP;
      end
      S_JUMP: begin
        redirect_valid_o = 1'b1;
        if (redirect_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

`ifdef CSR_TRAP_VECTORED_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) mtvec_mode_q <= (MTVEC_RST[1:0] == 2'b01) ? 2'b01 : 2'b00;
    else if (csr_wr && (csr_addr_i == A_MTVEC))
      mtvec_mode_q <= csr_wdata_i[1] ? 2'b00 : csr_wdata_i[1:0];
  end
`else
  assign mtvec_mode_q = 2'b00;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      priv_q        <= PRIV_M;
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= PRIV_M;
      mie_q         <= '0;
      mip_q         <= '0;
      mtvec_base_q  <= MTVEC_RST[XLEN-1:2];
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      mip_q <= {m_ext_irq_i, m_sw_irq_i, m_timer_irq_i};
      if (exc_take || irq_take) begin
        mpie_q        <= mstatus_mie_q;
        mstatus_mie_q <= 1'b0;
        mpp_q         <= priv_q;
        priv_q        <= PRIV_M;
        if (exc_take) begin
          mepc_q        <= exc_pc_i & LOW2_CLR;
          mcause_q      <= exc_cause_i;
          mtval_q       <= exc_tval_i;
          redirect_pc_q <= trap_base;
        end else begin
          mepc_q        <= irq_pc_i & LOW2_CLR;
          mcause_q      <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
          mtval_q       <= '0;
          redirect_pc_q <= irq_target;
        end
      end else if (mret_take) begin
        priv_q        <= mpp_q;
        mstatus_mie_q <= mpie_q;
        mpie_q        <= 1'b1;
        mpp_q         <= 2'b00;
        redirect_pc_q <= mepc_q;
      end else if (csr_wr) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            mstatus_mie_q <= csr_wdata_i[3];
            mpie_q        <= csr_wdata_i[7];
            mpp_q         <= (csr_wdata_i[12:11] == 2'b10) ? 2'b00 : csr_wdata_i[12:11];
          end
          A_MIE:    mie_q        <= {csr_wdata_i[11], csr_wdata_i[3], csr_wdata_i[7]};
          A_MTVEC:  mtvec_base_q <= csr_wdata_i[XLEN-1:2];
          A_MEPC:   mepc_q       <= csr_wdata_i & LOW2_CLR;
          A_MCAUSE: mcause_q     <= csr_wdata_i;
          A_MTVAL:  mtval_q      <= csr_wdata_i;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: inputs change on the falling edge, outputs are checked
// 1ns later. Vectored-mode expectations follow CSR_TRAP_VECTORED_EN.
`timescale 1ns/1ps
module tb_csr_trap_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_ready, mret_valid, irq_take_en;
  logic [63:0] exc_cause, exc_pc, exc_tval, irq_pc;
  logic        m_ext, m_sw, m_timer;
  logic        csr_valid, csr_ready, csr_we, csr_illegal;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic        flush, redirect_valid, redirect_ready;
  logic [63:0] redirect_pc;
  logic [1:0]  priv;

  int n_vec = 0;
  int n_err = 0;

  csr_trap_unit #(.XLEN(64), .MTVEC_RST(64'h0)) dut (
    .clk_i(clk), .rst_i(rst),
    .exc_valid_i(exc_valid), .exc_ready_o(exc_ready), .exc_cause_i(exc_cause),
    .exc_pc_i(exc_pc), .exc_tval_i(exc_tval), .mret_valid_i(mret_valid),
    .irq_take_en_i(irq_take_en), .irq_pc_i(irq_pc),
    .m_ext_irq_i(m_ext), .m_sw_irq_i(m_sw), .m_timer_irq_i(m_timer),
    .csr_valid_i(csr_valid), .csr_ready_o(csr_ready), .csr_we_i(csr_we),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
    .csr_illegal_o(csr_illegal), .flush_o(flush), .redirect_valid_o(redirect_valid),
    .redirect_ready_i(redirect_ready), .redirect_pc_o(redirect_pc), .priv_o(priv)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    csr_valid = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    #1 check("csr_wr_ready", csr_ready, 1'b1);
    tick();
    csr_valid = 1'b0; csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    csr_valid = 1'b1; csr_we = 1'b0; csr_addr = a;
    #1 check(tag, csr_rdata, exp);
    csr_valid = 1'b0;
    tick();
  endtask

  task automatic handshake();
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    #1 check("redir_drop", redirect_valid, 1'b0);
    check("back_idle", exc_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; exc_valid = 0; mret_valid = 0; irq_take_en = 0;
    exc_cause = 0; exc_pc = 0; exc_tval = 0; irq_pc = 0;
    m_ext = 0; m_sw = 0; m_timer = 0;
    csr_valid = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0; redirect_ready = 0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    #1 check("rst_priv", priv, 2'b11);
    check("rst_flush", flush, 1'b0);
    check("rst_rvalid", redirect_valid, 1'b0);
    check("rst_rpc", redirect_pc, 64'h0);
    check("rst_exc_ready", exc_ready, 1'b1);
    tick();
    csr_rd(12'h300, 64'h1800, "rst_mstatus");
    csr_rd(12'h305, 64'h0, "rst_mtvec");

    // exception with simultaneous mret and CSR write
    csr_wr(12'h305, 64'h8000);
    csr_rd(12'h305, 64'h8000, "mtvec_rd");
    exc_valid = 1; exc_cause = 64'd2; exc_pc = 64'h1002; exc_tval = 64'hdead;
    mret_valid = 1; csr_valid = 1; csr_we = 1; csr_addr = 12'h300; csr_wdata = 64'h0;
    #1 check("exc_ready_n", exc_ready, 1'b1);
    check("csr_blocked", csr_ready, 1'b0);
    tick();
    exc_valid = 0; mret_valid = 0; csr_valid = 0; csr_we = 0;
    #1 check("exc_flush", flush, 1'b1);
    check("exc_rvalid_n1", redirect_valid, 1'b0);
    check("exc_busy", exc_ready, 1'b0);
    tick();
    #1 check("exc_flush_n2", flush, 1'b0);
    check("exc_rvalid", redirect_valid, 1'b1);
    check("exc_rpc", redirect_pc, 64'h8000);
    check("exc_priv", priv, 2'b11);
    handshake();
    tick();
    csr_rd(12'h341, 64'h1000, "exc_mepc");
    csr_rd(12'h342, 64'h2, "exc_mcause");
    csr_rd(12'h343, 64'hdead, "exc_mtval");
    csr_rd(12'h300, 64'h1800, "exc_mstatus");

    // interrupt: MEI beats MTI
    csr_wr(12'h300, 64'h1808);
    csr_wr(12'h304, 64'hffff);
    csr_rd(12'h304, 64'h888, "mie_warl");
    m_timer = 1; m_ext = 1;
    tick();
    csr_rd(12'h344, 64'h880, "mip_rd");
    irq_take_en = 1; irq_pc = 64'h2000;
    tick();
    irq_take_en = 0;
    #1 check("irq_flush", flush, 1'b1);
    tick();
    #1 check("irq_rvalid", redirect_valid, 1'b1);
    check("irq_rpc", redirect_pc, 64'h8000);
    handshake();
    m_timer = 0; m_ext = 0;
    tick();
    csr_rd(12'h342, 64'h800000000000000b, "irq_mcause");
    csr_rd(12'h341, 64'h2000, "irq_mepc");
    csr_rd(12'h343, 64'h0, "irq_mtval");
    csr_rd(12'h300, 64'h1880, "irq_mstatus");

    // timer interrupt with mtvec mode 01
    csr_wr(12'h305, 64'h8001);
`ifdef CSR_TRAP_VECTORED_EN
    csr_rd(12'h305, 64'h8001, "mtvec_vec");
`else
    csr_rd(12'h305, 64'h8000, "mtvec_vec");
`endif
    csr_wr(12'h300, 64'h1808);
    m_timer = 1;
    tick();
    irq_take_en = 1;
    tick();
    irq_take_en = 0;
    tick();
`ifdef CSR_TRAP_VECTORED_EN
    #1 check("mti_rpc", redirect_pc, 64'h801c);
`else
    #1 check("mti_rpc", redirect_pc, 64'h8000);
`endif
    handshake();
    m_timer = 0;
    tick();
    csr_rd(12'h342, 64'h8000000000000007, "mti_mcause");

    // mstatus WARL, mepc alignment, then mret
    csr_wr(12'h300, 64'h1000);
    csr_rd(12'h300, 64'h0, "mpp10_warl");
    csr_wr(12'h300, 64'h0080);
    csr_rd(12'h300, 64'h0080, "mstatus_mpie");
    csr_wr(12'h341, 64'h3003);
    csr_rd(12'h341, 64'h3000, "mepc_align");
    mret_valid = 1;
    #1 check("mret_csr_blocked", csr_ready, 1'b0);
    tick();
    mret_valid = 0;
    #1 check("mret_flush", flush, 1'b1);
    tick();
    #1 check("mret_rvalid", redirect_valid, 1'b1);
    check("mret_rpc", redirect_pc, 64'h3000);
    check("mret_priv", priv, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 check("hold_rvalid", redirect_valid, 1'b1);
      check("hold_rpc", redirect_pc, 64'h3000);
    end
    handshake();
    tick();
    csr_rd(12'h300, 64'h0088, "mret_mstatus");

    // illegal accesses
    csr_valid = 1; csr_we = 0; csr_addr = 12'h7c0;
    #1 check("unmapped_rd", csr_rdata, 64'h0);
    check("unmapped_ill", csr_illegal, 1'b1);
    csr_we = 1; csr_addr = 12'h344; csr_wdata = 64'h888;
    #1 check("mip_wr_ill", csr_illegal, 1'b1);
    csr_addr = 12'h341;
    #1 check("legal_wr", csr_illegal, 1'b0);
    csr_valid = 0; csr_we = 0;
    tick();

    // exception from U, then reset during JUMP
    exc_valid = 1; exc_cause = 64'd5; exc_pc = 64'h4000; exc_tval = 64'h0;
    tick();
    exc_valid = 0;
    tick();
    #1 check("u_exc_rpc", redirect_pc, 64'h8000);
    check("u_exc_priv", priv, 2'b11);
    csr_valid = 1; csr_addr = 12'h300;
    #1 check("u_exc_mstatus", csr_rdata, 64'h0080);
    csr_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1 check("rst2_rvalid", redirect_valid, 1'b0);
    check("rst2_flush", flush, 1'b0);
    check("rst2_rpc", redirect_pc, 64'h0);
    check("rst2_idle", exc_ready, 1'b1);
    check("rst2_priv", priv, 2'b11);
    tick();
    csr_rd(12'h300, 64'h1800, "rst2_mstatus");
    csr_rd(12'h304, 64'h0, "rst2_mie");
    csr_rd(12'h305, 64'h0, "rst2_mtvec");
    csr_rd(12'h341, 64'h0, "rst2_mepc");
    csr_rd(12'h342, 64'h0, "rst2_mcause");
    csr_rd(12'h343, 64'h0, "rst2_mtval");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
